// File: rtl/out_port_fifo_if.sv
// Handshake bundle between the CPU output port, the FIFO and the downstream consumer.
// The slave modport is the FIFO's view; master is the CPU/consumer side.
interface out_port_fifo_if #(
    parameter int WIDTH = 8
);
    logic             out_we;
    logic [WIDTH-1:0] out_data;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport slave (
        input  out_we,
        input  out_data,
        input  m_ready,
        output m_valid,
        output m_data
    );

    modport master (
        output out_we,
        output out_data,
        output m_ready,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/out_port_fifo.sv
// First-word-fall-through queue behind the CPU external output port.
// A push into a full queue is dropped and raises the sticky ovf flag.
module out_port_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    out_port_fifo_if.slave bus,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    input  logic          ovf_clr
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Flags come only from the count register, so no path from out_we or m_ready.
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    assign bus.m_valid = !empty;
    assign bus.m_data  = mem[rd_ptr];

    assign pop  = bus.m_valid && bus.m_ready;
    assign push = bus.out_we && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A dropped push outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (bus.out_we && full && !pop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo: a vector table for the main sequences plus
// hand-written wrap-around and reset-between-edges checks.
module tb_out_port_fifo;
    logic       clk;
    logic       rst;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       ovf;
    logic       ovf_clr;

    int errors = 0;
    int checks = 0;

    out_port_fifo_if #(.WIDTH(8)) bus ();

    out_port_fifo #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       we;
        logic [7:0] d;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic [3:0] ec;
        logic       ef;
        logic       eo;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rst_n, input logic we, input logic [7:0] d,
                       input logic rdy, input logic clr, input logic ev,
                       input logic [7:0] ed, input logic [3:0] ec,
                       input logic ef, input logic eo);
        vec_t v;
        v.rst_n = rst_n; v.we = we; v.d = d; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.ec = ec; v.ef = ef; v.eo = eo;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst_n, input logic we, input logic [7:0] d,
                         input logic rdy, input logic clr);
        rst = rst_n; bus.out_we = we; bus.out_data = d; bus.m_ready = rdy; ovf_clr = clr;
    endtask

    int exp_out;
    int pushed;

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // rst we  data  rdy clr | valid data  count full ovf
        add(0, 0, 8'h00, 0, 0,   0, 8'h00, 4'd0, 0, 0);
        add(1, 1, 8'h11, 0, 0,   1, 8'h11, 4'd1, 0, 0);
        add(1, 1, 8'h22, 0, 0,   1, 8'h11, 4'd2, 0, 0);
        add(1, 1, 8'h33, 0, 0,   1, 8'h11, 4'd3, 0, 0);
        add(1, 0, 8'h00, 1, 0,   1, 8'h22, 4'd2, 0, 0);
        add(1, 0, 8'h00, 1, 0,   1, 8'h33, 4'd1, 0, 0);
        add(1, 0, 8'h00, 1, 0,   0, 8'h00, 4'd0, 0, 0);
        add(1, 0, 8'h00, 1, 0,   0, 8'h00, 4'd0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(1, 1, 8'(i), 0, 0, 1, 8'h00, 4'(i + 1), (i == 7), 0);
        add(1, 1, 8'hAA, 0, 0,   1, 8'h00, 4'd8, 1, 1);
        add(1, 0, 8'h00, 0, 1,   1, 8'h00, 4'd8, 1, 0);
        add(1, 1, 8'hAB, 0, 1,   1, 8'h00, 4'd8, 1, 1);
        add(1, 0, 8'h00, 0, 1,   1, 8'h00, 4'd8, 1, 0);
        add(1, 1, 8'h55, 1, 0,   1, 8'h01, 4'd8, 1, 0);
        for (int i = 2; i < 8; i++)
            add(1, 0, 8'h00, 1, 0, 1, 8'(i), 4'(9 - i), 0, 0);
        add(1, 0, 8'h00, 1, 0,   1, 8'h55, 4'd1, 0, 0);
        add(1, 0, 8'h00, 1, 0,   0, 8'h00, 4'd0, 0, 0);
        for (int i = 1; i <= 5; i++)
            add(1, 1, 8'(i), 0, 0, 1, 8'h01, 4'(i), 0, 0);
        add(0, 1, 8'h99, 0, 0,   0, 8'h00, 4'd0, 0, 0);
        add(1, 1, 8'h3C, 0, 0,   1, 8'h3C, 4'd1, 0, 0);
        for (int i = 0; i < 4; i++)
            add(1, 0, 8'h00, 0, 0, 1, 8'h3C, 4'd1, 0, 0);

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].rst_n, vt[i].we, vt[i].d, vt[i].rdy, vt[i].clr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d m_valid", i), 32'(bus.m_valid), 32'(vt[i].ev));
            chk($sformatf("v%0d count", i), 32'(count), 32'(vt[i].ec));
            chk($sformatf("v%0d full", i), 32'(full), 32'(vt[i].ef));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(vt[i].ec == 4'd0));
            chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(vt[i].eo));
            if (vt[i].ev)
                chk($sformatf("v%0d m_data", i), 32'(bus.m_data), 32'(vt[i].ed));
        end

        // Wrap-around: drain the leftover entry, then stream 0..19 at depth 4.
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("wrap pre-empty", 32'(empty), 32'd1);
        exp_out = 0;
        pushed  = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'(pushed), 1'b0, 1'b0);
            pushed++;
            @(negedge clk);
        end
        chk("wrap fill count", 32'(count), 32'd4);

        // rst low only between edges must not disturb state.
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("glitch-rst count", 32'(count), 32'd4);
        chk("glitch-rst m_data", 32'(bus.m_data), 32'd0);

        while (exp_out < 20) begin
            drive(1'b1, pushed < 20, 8'(pushed), 1'b1, 1'b0);
            chk($sformatf("wrap out%0d", exp_out), 32'(bus.m_data), 32'(exp_out));
            if (pushed < 20) pushed++;
            exp_out++;
            @(negedge clk);
            if (exp_out < 20 && (count < 4'd1 || count > 4'd7)) begin
                errors++;
                $display("FAIL wrap count range: got %0d expected 1..7", count);
            end
        end
        chk("wrap end empty", 32'(empty), 32'd1);
        chk("wrap end ovf", 32'(ovf), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
